// File: rtl/mfreg_seq_pkg.sv
// mfreg_seq_pkg: shared encodings for the mfreg command sequencer.
//   op_e    : command opcodes carried on cmd_op
//   state_e : sequencer FSM states
package mfreg_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLR   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mfreg_seq.sv
// mfreg_seq: expands one valid/ready command into per-cycle mfreg controls.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready   command handshake; ready only in IDLE
//   cmd_op                00 LOAD, 01 SHR, 10 SHL, 11 CLEAR
//   cmd_data              load value or serial shift pattern
//   cmd_len               shift count (0 or >WIDTH means WIDTH)
//   abort                 ends an in-progress shift after the current cycle
//   busy                  command in progress
//   done                  one-cycle pulse after the last control cycle
//   mf_I/mf_rst/mf_ld/mf_shr/mf_shl/mf_shin   controls to mfreg
// All outputs decode registered state only.
module mfreg_seq
  import mfreg_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mf_I,
  output logic             mf_rst,
  output logic             mf_ld,
  output logic             mf_shr,
  output logic             mf_shl,
  output logic             mf_shin
);

  localparam logic [LEN_W-1:0] WLEN = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;   // load value, or remaining shift pattern
  logic [LEN_W-1:0] cnt_q, cnt_d;   // shift bits still to emit
  logic             shl_q, shl_d;   // shift direction of the current command
  logic [LEN_W-1:0] len_eff;

  // Zero and oversize lengths both mean a full-width shift.
  always_comb begin
    len_eff = cmd_len;
    if (cmd_len == '0 || cmd_len > WLEN) len_eff = WLEN;
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    shl_d   = shl_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          pat_d = cmd_data;
          cnt_d = len_eff;
          shl_d = (op_e'(cmd_op) == OP_SHL);
          case (op_e'(cmd_op))
            OP_LOAD: state_d = ST_LOAD;
            OP_CLR:  state_d = ST_CLR;
            default: state_d = ST_SHIFT;
          endcase
        end
      end
      ST_LOAD, ST_CLR: state_d = ST_DONE;
      ST_SHIFT: begin
        // Pattern moves so the next bit to emit sits at the output end.
        pat_d = shl_q ? {pat_q[WIDTH-2:0], 1'b0} : {1'b0, pat_q[WIDTH-1:1]};
        cnt_d = cnt_q - ONE;
        // An abort still lets the current cycle's shift land.
        if (cnt_q == ONE || abort) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      shl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      shl_q   <= shl_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign done      = (state_q == ST_DONE);
  assign mf_ld     = (state_q == ST_LOAD);
  assign mf_rst    = (state_q == ST_CLR);
  assign mf_shr    = (state_q == ST_SHIFT) & ~shl_q;
  assign mf_shl    = (state_q == ST_SHIFT) &  shl_q;
  assign mf_I      = mf_ld ? pat_q : '0;
  assign mf_shin   = (state_q == ST_SHIFT) & (shl_q ? pat_q[WIDTH-1] : pat_q[0]);

endmodule
